// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared types and default timing constants for the alarm trigger block.
//   state_t          : alarm state machine encoding (IDLE, RING, SNOOZE)
//   TONE_DIV_DEF     : CLK100MHZ cycles per buzzer half-period (1 kHz tone)
//   RING_SECS_DEF    : seconds of ringing before the alarm stops by itself
//   SNOOZE_SECS_DEF  : snooze length in seconds
//   max_int()        : helper used to size the shared seconds counter
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int TONE_DIV_DEF    = 50000;
  localparam int RING_SECS_DEF   = 60;
  localparam int SNOOZE_SECS_DEF = 300;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen
// Free-running square-wave generator for the buzzer tone. The output toggles
// once every DIV clock cycles, giving a period of 2*DIV cycles.
//   CLK100MHZ : system clock
//   rst_n     : asynchronous active-low reset, output starts low
//   tone      : square-wave output
module tone_gen #(
  parameter int DIV = 50000
) (
  input  logic CLK100MHZ,
  input  logic rst_n,
  output logic tone
);

  // A divide-by-one still needs a one-bit counter to stay legal.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..DIV-1 and flip the tone each time the count wraps.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger
// Compares the running 12-hour time against the alarm time, starts ringing at
// the first cycle of the alarm minute and runs the ring / snooze / dismiss
// state machine that drives the buzzer.
//   CLK100MHZ                 : system clock (only clock)
//   rst_n                     : asynchronous active-low reset
//   sec_tick                  : one-cycle pulse per second
//   cur_hourten..cur_min      : current time, BCD digits
//   alarm_hourten..alarm_min  : alarm time, BCD digits
//   alarm_on                  : alarm armed switch
//   snooze_btn, dismiss_btn   : debounced button levels
//   ringing                   : high while in RING
//   snoozing                  : high while in SNOOZE
//   buzzer                    : gated 1 kHz tone for the buzzer pin
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int TONE_DIV    = TONE_DIV_DEF,
  parameter int RING_SECS   = RING_SECS_DEF,
  parameter int SNOOZE_SECS = SNOOZE_SECS_DEF
) (
  input  logic       CLK100MHZ,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [3:0] cur_hourten,
  input  logic [3:0] cur_hour,
  input  logic [3:0] cur_minten,
  input  logic [3:0] cur_min,
  input  logic [3:0] alarm_hourten,
  input  logic [3:0] alarm_hour,
  input  logic [3:0] alarm_minten,
  input  logic [3:0] alarm_min,
  input  logic       alarm_on,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int CNT_MAX = max_int(RING_SECS, SNOOZE_SECS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The counter is compared against the value it holds just before the
  // final tick, so the state changes on the tick that completes the period.
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

  state_t           state;
  state_t           state_d;
  logic             match;
  logic             match_q;
  logic             snooze_q;
  logic             dismiss_q;
  logic             trigger;
  logic             snooze_p;
  logic             dismiss_p;
  logic             ring_done;
  logic             snooze_done;
  logic             entering;
  logic [CNT_W-1:0] sec_cnt;
  logic             beep_on;
  logic             tone;
  logic             buzzer_q;

  tone_gen #(
    .DIV(TONE_DIV)
  ) u_tone_gen (
    .CLK100MHZ(CLK100MHZ),
    .rst_n    (rst_n),
    .tone     (tone)
  );

  assign match = (cur_hourten == alarm_hourten) && (cur_hour == alarm_hour) &&
                 (cur_minten == alarm_minten) && (cur_min == alarm_min);

  assign trigger     = match & ~match_q & alarm_on;
  assign snooze_p    = snooze_btn & ~snooze_q;
  assign dismiss_p   = dismiss_btn & ~dismiss_q;
  assign ring_done   = sec_tick && (sec_cnt == RING_LAST);
  assign snooze_done = sec_tick && (sec_cnt == SNOOZE_LAST);
  assign entering    = (state_d != state);

  // Edge-detect registers reset high: a reset inside the alarm minute, or
  // with a button already held, must not look like a fresh rising edge.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      match_q   <= 1'b1;
      snooze_q  <= 1'b1;
      dismiss_q <= 1'b1;
    end else begin
      match_q   <= match;
      snooze_q  <= snooze_btn;
      dismiss_q <= dismiss_btn;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Disarming wins over everything; within RING/SNOOZE dismiss beats snooze.
  // A trigger while already ringing or snoozing is simply not looked at.
  always_comb begin
    state_d = state;
    if (!alarm_on) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) state_d = RING;
        end
        RING: begin
          if (dismiss_p)      state_d = IDLE;
          else if (snooze_p)  state_d = SNOOZE;
          else if (ring_done) state_d = IDLE;
        end
        SNOOZE: begin
          if (dismiss_p)        state_d = IDLE;
          else if (snooze_done) state_d = RING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Seconds spent in the current state. A tick arriving in the same cycle as
  // a state change is lost on purpose: the counter is clearing for the new
  // state.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
    end else if (entering || (state == IDLE)) begin
      sec_cnt <= '0;
    end else if (sec_tick) begin
      sec_cnt <= sec_cnt + 1'b1;
    end
  end

  // Beep cadence: starts audible on entry to RING, then alternates every
  // second so the alarm sounds 1 s on / 1 s off.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      beep_on <= 1'b0;
    end else if (entering && (state_d == RING)) begin
      beep_on <= 1'b1;
    end else if (state_d != RING) begin
      beep_on <= 1'b0;
    end else if (sec_tick) begin
      beep_on <= ~beep_on;
    end
  end

  // Registered gated tone. The final AND with the live state keeps the pin
  // silent in the first cycle after leaving RING.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= (state == RING) & tone & beep_on;
    end
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = buzzer_q & ringing;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger
// Self-checking bench for alarm_trigger with short timing parameters
// (TONE_DIV=4, RING_SECS=3, SNOOZE_SECS=2, one sec_tick every 20 cycles).
// A behavioural model tracks mode, seconds counted and the tone phase; a
// compare process checks every cycle, and directed scenarios add literal
// expectations before a randomized phase.
module tb_alarm_trigger;

  localparam int TONE_DIV    = 4;
  localparam int RING_SECS   = 3;
  localparam int SNOOZE_SECS = 2;
  localparam int TICK_PERIOD = 20;

  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;

  logic       CLK100MHZ;
  logic       rst_n;
  logic       sec_tick;
  logic [3:0] cur_hourten, cur_hour, cur_minten, cur_min;
  logic [3:0] alarm_hourten, alarm_hour, alarm_minten, alarm_min;
  logic       alarm_on;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;

  int checks = 0;
  int errors = 0;
  int tickPhase = 0;

  alarm_trigger #(
    .TONE_DIV   (TONE_DIV),
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .rst_n        (rst_n),
    .sec_tick     (sec_tick),
    .cur_hourten  (cur_hourten),
    .cur_hour     (cur_hour),
    .cur_minten   (cur_minten),
    .cur_min      (cur_min),
    .alarm_hourten(alarm_hourten),
    .alarm_hour   (alarm_hour),
    .alarm_minten (alarm_minten),
    .alarm_min    (alarm_min),
    .alarm_on     (alarm_on),
    .snooze_btn   (snooze_btn),
    .dismiss_btn  (dismiss_btn),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .buzzer       (buzzer)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Behavioural model: which mode the alarm is in, how many seconds have
  // been counted there, and how many clock edges the tone has seen.
  int mMode;
  int mTicks;
  int mEdges;
  bit mPrevMatch, mPrevSnooze, mPrevDismiss;
  bit mBuzzReg;

  always @(posedge CLK100MHZ or negedge rst_n) begin
    bit matchNow, trig, sP, dP, toneNow;
    int nextMode, limit;
    if (!rst_n) begin
      mMode        = M_IDLE;
      mTicks       = 0;
      mEdges       = 0;
      mPrevMatch   = 1'b1;
      mPrevSnooze  = 1'b1;
      mPrevDismiss = 1'b1;
      mBuzzReg     = 1'b0;
    end else begin
      matchNow = ({cur_hourten, cur_hour, cur_minten, cur_min} ==
                  {alarm_hourten, alarm_hour, alarm_minten, alarm_min});
      trig = matchNow && !mPrevMatch && alarm_on;
      sP   = snooze_btn && !mPrevSnooze;
      dP   = dismiss_btn && !mPrevDismiss;
      // Tone level after mEdges edges; beep is on during even seconds.
      toneNow  = ((mEdges / TONE_DIV) % 2) == 1;
      mBuzzReg = (mMode == M_RING) && toneNow && ((mTicks % 2) == 0);
      limit    = (mMode == M_RING) ? RING_SECS : SNOOZE_SECS;
      nextMode = mMode;
      if (!alarm_on) nextMode = M_IDLE;
      else if (mMode == M_IDLE) begin
        if (trig) nextMode = M_RING;
      end
      else if (dP) nextMode = M_IDLE;
      else if (mMode == M_RING && sP) nextMode = M_SNOOZE;
      else if (sec_tick && (mTicks + 1 == limit))
        nextMode = (mMode == M_RING) ? M_IDLE : M_RING;
      if (nextMode != mMode) mTicks = 0;
      else if (mMode != M_IDLE && sec_tick) mTicks = mTicks + 1;
      mMode        = nextMode;
      mPrevMatch   = matchNow;
      mPrevSnooze  = snooze_btn;
      mPrevDismiss = dismiss_btn;
      mEdges       = mEdges + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK100MHZ) begin
    checkOutput("model_ringing", int'(ringing), int'(mMode == M_RING));
    checkOutput("model_snoozing", int'(snoozing), int'(mMode == M_SNOOZE));
    checkOutput("model_buzzer", int'(buzzer), int'(mBuzzReg && (mMode == M_RING)));
  end

  // Advance one cycle and drive the inputs for it just after the edge.
  task automatic applyStimulus();
    @(posedge CLK100MHZ);
    #1;
    tickPhase = tickPhase + 1;
    sec_tick  = ((tickPhase % TICK_PERIOD) == 0);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic setCur(input logic [3:0] h10, input logic [3:0] h,
                        input logic [3:0] m10, input logic [3:0] m);
    cur_hourten = h10; cur_hour = h; cur_minten = m10; cur_min = m;
  endtask

  // Step the time into 07:30 from 07:29 and confirm ringing next cycle.
  task automatic triggerAlarm(input string name);
    setCur(4'd0, 4'd7, 4'd2, 4'd9);
    applyStimulus();
    setCur(4'd0, 4'd7, 4'd3, 4'd0);
    applyStimulus();
    checkOutput(name, int'(ringing), 1);
  endtask

  initial begin
    int dur, buzzHigh, guard, sawRing, r;
    rst_n = 1'b0; sec_tick = 1'b0;
    alarm_hourten = 4'd0; alarm_hour = 4'd7; alarm_minten = 4'd3; alarm_min = 4'd0;
    setCur(4'd0, 4'd7, 4'd2, 4'd9);
    alarm_on = 1'b1; snooze_btn = 1'b0; dismiss_btn = 1'b0;
    runCycles(3);
    checkOutput("reset_ringing", int'(ringing), 0);
    checkOutput("reset_snoozing", int'(snoozing), 0);
    checkOutput("reset_buzzer", int'(buzzer), 0);
    rst_n = 1'b1;
    runCycles(5);

    // Trigger, then let it ring out untouched.
    $display("[TB] trigger and auto-stop");
    triggerAlarm("trigger_ringing");
    dur = 0; buzzHigh = 0;
    while (ringing === 1'b1 && dur < 200) begin
      dur = dur + 1;
      if (buzzer === 1'b1) buzzHigh = buzzHigh + 1;
      applyStimulus();
    end
    checkOutput("autostop_window", int'(dur >= 41 && dur <= 60), 1);
    checkOutput("buzzer_active_in_ring", int'(buzzHigh > 0), 1);
    sawRing = 0;
    for (int i = 0; i < 30; i++) begin
      if (ringing === 1'b1) sawRing = 1;
      applyStimulus();
    end
    checkOutput("no_retrigger_same_minute", sawRing, 0);

    // Snooze, expiry back into RING, then dismiss.
    $display("[TB] snooze and dismiss");
    triggerAlarm("trigger_for_snooze");
    runCycles(4);
    snooze_btn = 1'b1;
    applyStimulus();
    checkOutput("snooze_entered", int'(snoozing), 1);
    checkOutput("snooze_buzzer_quiet", int'(buzzer), 0);
    snooze_btn = 1'b0;
    guard = 0;
    while (ringing !== 1'b1 && guard < 100) begin
      guard = guard + 1;
      applyStimulus();
    end
    checkOutput("snooze_expiry_rings", int'(ringing), 1);
    dismiss_btn = 1'b1;
    applyStimulus();
    checkOutput("dismiss_ringing", int'(ringing), 0);
    checkOutput("dismiss_snoozing", int'(snoozing), 0);
    dismiss_btn = 1'b0;
    runCycles(3);

    // Both buttons rising together: dismiss wins.
    $display("[TB] simultaneous buttons");
    triggerAlarm("trigger_for_both");
    runCycles(2);
    snooze_btn = 1'b1; dismiss_btn = 1'b1;
    applyStimulus();
    checkOutput("both_ringing", int'(ringing), 0);
    checkOutput("both_snoozing", int'(snoozing), 0);
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    runCycles(3);

    // Disarm during snooze, re-arm inside the same minute.
    $display("[TB] disarm during snooze");
    triggerAlarm("trigger_for_disarm");
    snooze_btn = 1'b1;
    applyStimulus();
    checkOutput("disarm_snooze_entered", int'(snoozing), 1);
    snooze_btn = 1'b0;
    alarm_on = 1'b0;
    applyStimulus();
    checkOutput("disarm_snoozing", int'(snoozing), 0);
    alarm_on = 1'b1;
    sawRing = 0;
    for (int i = 0; i < 30; i++) begin
      if (ringing === 1'b1) sawRing = 1;
      applyStimulus();
    end
    checkOutput("rearm_no_ring", sawRing, 0);

    // Reset inside the alarm minute, then reset while ringing.
    $display("[TB] reset behaviour");
    alarm_hourten = 4'd1; alarm_hour = 4'd2; alarm_minten = 4'd0; alarm_min = 4'd0;
    setCur(4'd1, 4'd2, 4'd0, 4'd0);
    rst_n = 1'b0;
    runCycles(3);
    rst_n = 1'b1;
    sawRing = 0;
    for (int i = 0; i < 30; i++) begin
      if (ringing === 1'b1) sawRing = 1;
      applyStimulus();
    end
    checkOutput("reset_in_minute_no_ring", sawRing, 0);
    setCur(4'd1, 4'd1, 4'd5, 4'd9);
    applyStimulus();
    setCur(4'd1, 4'd2, 4'd0, 4'd0);
    applyStimulus();
    checkOutput("noon_trigger", int'(ringing), 1);
    guard = 0;
    while (buzzer !== 1'b1 && guard < 100) begin
      guard = guard + 1;
      applyStimulus();
    end
    checkOutput("noon_buzzer_on", int'(buzzer), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_buzzer", int'(buzzer), 0);
    checkOutput("async_reset_ringing", int'(ringing), 0);
    runCycles(2);
    rst_n = 1'b1;

    // Randomized phase around the alarm minute.
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) setCur(4'd1, 4'd2, 4'd0, 4'd0);
      else if (r < 6) setCur(4'd1, 4'd2, 4'd0, 4'($urandom_range(1, 9)));
      else if (r < 9) snooze_btn = ~snooze_btn;
      else if (r < 11) dismiss_btn = ~dismiss_btn;
      else if (r < 12) alarm_on = 1'b0;
      else if (r < 30) alarm_on = 1'b1;
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Consumes the alarm time set by the alarm-setting block and the running time from the 12-hour clock counter, detects the start of the alarm minute, and drives the buzzer through a ring / snooze / dismiss state machine. Sits between the time-keeping and alarm-setting blocks and the board buzzer/LED pins. Snooze and dismiss inputs are already-debounced button levels, edge-detected internally.

## Interface
- TONE_DIV, 50000: CLK100MHZ cycles per buzzer half-period (1 kHz tone).
- RING_SECS, 60: seconds of ringing before auto-stop.
- SNOOZE_SECS, 300: snooze length in seconds.
- CLK100MHZ  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sec_tick  in  1  one-cycle pulse per second from the time-keeping block.
- cur_hourten, cur_hour, cur_minten, cur_min  in  4 each  current time, BCD.
- alarm_hourten, alarm_hour, alarm_minten, alarm_min  in  4 each  alarm time, BCD.
- alarm_on  in  1  alarm armed switch (level).
- snooze_btn  in  1  debounced snooze button (level).
- dismiss_btn  in  1  debounced dismiss button (level).
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- buzzer  out  1  gated tone to buzzer pin.

## Operation
- match = all four current digits equal the alarm digits (combinational); match_q is its registered copy.
- trigger = match & ~match_q & alarm_on (rising edge of match only).
- snooze_p, dismiss_p: rising edges of snooze_btn / dismiss_btn via registered copies.
- States (alarm_pkg::state_t): IDLE, RING, SNOOZE.
- IDLE -> RING on trigger. Otherwise stay.
- RING -> IDLE on dismiss_p; RING -> SNOOZE on snooze_p; RING -> IDLE when sec_cnt reaches RING_SECS.
- SNOOZE -> IDLE on dismiss_p; SNOOZE -> RING when sec_cnt reaches SNOOZE_SECS.
- alarm_on low: any state -> IDLE next edge; overrides everything.
- dismiss_p and snooze_p same cycle: dismiss wins.
- trigger while in RING or SNOOZE: ignored.
- sec_cnt: clog2(max(RING_SECS,SNOOZE_SECS)+1) bits; cleared on every state entry; increments on sec_tick in RING/SNOOZE; held at 0 in IDLE.
- beep_on: set to 1 on entry to RING, toggles on each sec_tick in RING (1 s on / 1 s off).
- Tone: tone_gen toggles tone_q every TONE_DIV cycles, free-running; buzzer = tone_q & beep_on, registered, forced 0 outside RING.

## Timing
- Reset values: state IDLE, ringing 0, snoozing 0, buzzer 0, sec_cnt 0, beep_on 0, match_q 1, button edge registers 1. match_q=1 means reset inside the alarm minute does not ring; held buttons at reset do not produce edges.
- Trigger latency: match first high in cycle n -> ringing high in cycle n+1; buzzer may go high from cycle n+2.
- Button edge: level rises in cycle n -> state change visible in cycle n+1.
- Auto-stop: ringing drops the cycle after the RING_SECS-th sec_tick counted in RING.
- Snooze expiry: ringing rises the cycle after the SNOOZE_SECS-th sec_tick in SNOOZE.
- sec_tick in the entry cycle of a state is not counted (counter is clearing).
- Alarm time edited to equal current time mid-minute: produces a match edge and triggers; intended.
- Reset mid-ring: all outputs 0 immediately (async), IDLE.

## Structure
- alarm_pkg: state_t enum, default RING_SECS / SNOOZE_SECS / TONE_DIV constants.
- Sub-module tone_gen (param DIV; CLK100MHZ, rst_n -> tone): free-running divider, reset output 0.
- Top: edge detectors, match logic, FSM, sec_cnt, beep_on, buzzer gating.

## Test plan
(Bench uses TONE_DIV=4, RING_SECS=3, SNOOZE_SECS=2, sec_tick every 20 cycles.)
- alarm 07:30, cur steps 07:29 -> 07:30, alarm_on=1 -> ringing=1 next cycle, buzzer toggles every 4 cycles during on-seconds.
- Ringing, no buttons -> ringing drops after 3rd sec_tick; cur stays 07:30 -> no re-trigger.
- Ringing, snooze_btn pulse -> snoozing=1, buzzer 0; after 2 sec_ticks -> ringing=1 again; dismiss_btn -> IDLE, both 0.
- snooze_btn and dismiss_btn rise same cycle in RING -> IDLE.
- alarm_on=0 during SNOOZE -> IDLE next cycle; alarm_on=1 with cur 07:30 unchanged -> no ring.
- Assert rst_n low while cur=alarm=12:00, release -> stays IDLE; rst_n low mid-ring -> buzzer 0 immediately.
